// File: rtl/program_loader.sv
// program_loader: streams valid/ready words into instruction memory from a base address and sequences cpu_en.
// Optional LOADER_CHECKSUM_EN: a trailer word after the image must equal the sum of the data words.
module program_loader #(
  parameter int DATA_W = 32,
  parameter int ADRS_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              halt,
  input  logic [ADRS_W-1:0] load_base,
  input  logic [ADRS_W:0]   load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic              w_enable,
  output logic [ADRS_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADRS_W:0]   word_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
  state_t            state;
  logic [ADRS_W-1:0] base;
  logic [ADRS_W:0]   len;
  logic              xfer, wr, fin, ok, oversize;
  assign xfer     = s_valid & s_ready;
  assign oversize = load_len > {1'b1, {ADRS_W{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
  localparam logic ZERO_RUN = 1'b0;
  logic [DATA_W-1:0] sum;
  // once every data word is in, the next transfer is the trailer
  assign wr  = xfer && word_cnt != len;
  assign fin = xfer && word_cnt == len;
  assign ok  = s_data == sum;
`else
  localparam logic ZERO_RUN = 1'b1;
  assign wr  = xfer;
  assign fin = xfer && (word_cnt + (ADRS_W+1)'(1)) == len;
  assign ok  = 1'b1;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      base          <= '0;
      len           <= '0;
      s_ready       <= 1'b0;
      w_instruction <= '0;
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      cpu_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      word_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      w_enable <= wr;
      done     <= 1'b0;
      if (wr) begin
        w_adrs        <= base + word_cnt[ADRS_W-1:0];
        w_instruction <= s_data;
        word_cnt      <= word_cnt + (ADRS_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
        sum           <= sum + s_data;
`endif
      end
      case (state)
        IDLE, RUN: begin
          if (start && oversize) begin
            err    <= 1'b1;
            state  <= IDLE;
            cpu_en <= 1'b0;
          end else if (start) begin
            err      <= 1'b0;
            base     <= load_base;
            len      <= load_len;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
            if (ZERO_RUN && load_len == '0) begin
              state  <= RUN;
              cpu_en <= 1'b1;
              done   <= 1'b1;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
              busy    <= 1'b1;
              cpu_en  <= 1'b0;
            end
          end else if (state == RUN && halt) begin
            state  <= IDLE;
            cpu_en <= 1'b0;
          end
        end
        LOAD: begin
          if (fin) begin
            s_ready <= 1'b0;
            state   <= ok ? FLUSH : IDLE;
            busy    <= ok;
            err     <= !ok;
          end
        end
        FLUSH: begin
          state  <= RUN;
          busy   <= 1'b0;
          cpu_en <= 1'b1;
          done   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
  logic        clk = 0, resetn = 0, start = 0, halt = 0, s_valid = 0;
  logic [10:0] load_base = 0;
  logic [11:0] load_len = 0;
  logic [31:0] s_data = 0;
  logic        s_ready, w_enable, cpu_en, busy, done, err;
  logic [31:0] w_instruction;
  logic [10:0] w_adrs;
  logic [11:0] word_cnt;
  int checks = 0, errs = 0;
  logic [10:0] wa[$];
  logic [31:0] wd[$];
  localparam logic [31:0] W0 = 32'hE000_301E, W1 = 32'hE023_001F, W2 = 32'hA100_0000;

  program_loader #(.DATA_W(32), .ADRS_W(11)) dut (
    .clk(clk), .resetn(resetn), .start(start), .halt(halt), .load_base(load_base),
    .load_len(load_len), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs), .cpu_en(cpu_en),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resetn && w_enable) begin
    wa.push_back(w_adrs);
    wd.push_back(w_instruction);
  end

  task automatic do_start(input logic [10:0] b, input logic [11:0] l, input logic h);
    start = 1; halt = h; load_base = b; load_len = l;
    @(negedge clk);
    start = 0; halt = 0;
  endtask

  task automatic send(input logic [31:0] d);
    s_valid = 1; s_data = d;
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({s_ready, w_enable, cpu_en, busy, done, err} !== 6'b0) begin errs++; $display("FAIL reset_flags got %b exp 000000", {s_ready, w_enable, cpu_en, busy, done, err}); end
    checks++; if (w_adrs !== 11'd0 || w_instruction !== 32'd0 || word_cnt !== 12'd0) begin errs++; $display("FAIL reset_bus got adrs=%0d data=%h cnt=%0d exp 0", w_adrs, w_instruction, word_cnt); end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_basic;
    wa.delete(); wd.delete();
    do_start(11'd1, 12'd3, 1'b0);
    checks++; if (s_ready !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL basic_load_entry got ready=%b busy=%b exp 1 1", s_ready, busy); end
    send(W0); send(W1); send(W2);
    checks++; if (s_ready !== 1'b0 || cpu_en !== 1'b0 || busy !== 1'b1 || w_enable !== 1'b1) begin errs++; $display("FAIL basic_flush got ready=%b cpu_en=%b busy=%b wen=%b exp 0 0 1 1", s_ready, cpu_en, busy, w_enable); end
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL basic_run got cpu_en=%b done=%b busy=%b exp 1 1 0", cpu_en, done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || cpu_en !== 1'b1) begin errs++; $display("FAIL basic_done_pulse got done=%b cpu_en=%b exp 0 1", done, cpu_en); end
    checks++; if (wa.size() !== 3 || word_cnt !== 12'd3) begin errs++; $display("FAIL basic_count got writes=%0d cnt=%0d exp 3 3", wa.size(), word_cnt); end
    else begin
      checks++; if (wa[0] !== 11'd1 || wa[1] !== 11'd2 || wa[2] !== 11'd3) begin errs++; $display("FAIL basic_adrs got %0d %0d %0d exp 1 2 3", wa[0], wa[1], wa[2]); end
      checks++; if (wd[0] !== W0 || wd[1] !== W1 || wd[2] !== W2) begin errs++; $display("FAIL basic_data got %h %h %h exp %h %h %h", wd[0], wd[1], wd[2], W0, W1, W2); end
    end
  endtask

  task automatic test_backpressure;
    logic [5:0] pat = 6'b101001;
    logic [31:0] w[3] = '{W0, W1, W2};
    int k = 0;
    wa.delete(); wd.delete();
    do_start(11'd1, 12'd3, 1'b0);
    checks++; if (cpu_en !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL bp_reload got cpu_en=%b ready=%b exp 0 1", cpu_en, s_ready); end
    for (int i = 0; i < 6; i++) begin
      s_valid = pat[i]; s_data = pat[i] ? w[k] : 32'hDEAD_BEEF;
      start = (i == 1); halt = (i == 1); load_base = 11'd100; load_len = 12'd1;
      if (pat[i]) k++;
      @(negedge clk);
    end
    s_valid = 0; start = 0; halt = 0;
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL bp_flush got cpu_en=%b busy=%b exp 0 1", cpu_en, busy); end
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || done !== 1'b1 || word_cnt !== 12'd3) begin errs++; $display("FAIL bp_run got cpu_en=%b done=%b cnt=%0d exp 1 1 3", cpu_en, done, word_cnt); end
    checks++; if (wa.size() !== 3) begin errs++; $display("FAIL bp_writes got %0d exp 3", wa.size()); end
    else begin
      checks++; if (wa[0] !== 11'd1 || wa[1] !== 11'd2 || wa[2] !== 11'd3 || wd[0] !== W0 || wd[1] !== W1 || wd[2] !== W2) begin errs++; $display("FAIL bp_content got %0d:%h %0d:%h %0d:%h exp 1 2 3 in order", wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]); end
    end
  endtask

  task automatic test_wrap_zero;
    wa.delete(); wd.delete();
    do_start(11'd2046, 12'd4, 1'b0);
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || err !== 1'b0) begin errs++; $display("FAIL wrap_run got cpu_en=%b err=%b exp 1 0", cpu_en, err); end
    checks++; if (wa.size() !== 4) begin errs++; $display("FAIL wrap_writes got %0d exp 4", wa.size()); end
    else begin
      checks++; if (wa[0] !== 11'd2046 || wa[1] !== 11'd2047 || wa[2] !== 11'd0 || wa[3] !== 11'd1 || wd[3] !== 32'h44) begin errs++; $display("FAIL wrap_adrs got %0d %0d %0d %0d exp 2046 2047 0 1", wa[0], wa[1], wa[2], wa[3]); end
    end
    halt = 1; @(negedge clk); halt = 0;
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL halt got cpu_en=%b busy=%b exp 0 0", cpu_en, busy); end
    wa.delete(); wd.delete();
    do_start(11'd0, 12'd0, 1'b0);
    checks++; if (cpu_en !== 1'b1 || done !== 1'b1 || s_ready !== 1'b0) begin errs++; $display("FAIL zero_run got cpu_en=%b done=%b ready=%b exp 1 1 0", cpu_en, done, s_ready); end
    @(negedge clk); @(negedge clk);
    checks++; if (wa.size() !== 0) begin errs++; $display("FAIL zero_writes got %0d exp 0", wa.size()); end
  endtask

  task automatic test_err_reload;
    halt = 1; @(negedge clk); halt = 0;
    do_start(11'd0, 12'd2049, 1'b0);
    checks++; if (err !== 1'b1 || cpu_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin errs++; $display("FAIL oversize got err=%b cpu_en=%b busy=%b ready=%b exp 1 0 0 0", err, cpu_en, busy, s_ready); end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", err); end
    wa.delete(); wd.delete();
    do_start(11'd7, 12'd1, 1'b0);
    checks++; if (err !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL err_clear got err=%b ready=%b exp 0 1", err, s_ready); end
    send(32'hCAFE_0007);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1) begin errs++; $display("FAIL reload1_run got cpu_en=%b exp 1", cpu_en); end
    do_start(11'd9, 12'd1, 1'b1);
    checks++; if (cpu_en !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL start_beats_halt got cpu_en=%b ready=%b exp 0 1", cpu_en, s_ready); end
    send(32'hCAFE_0009);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || done !== 1'b1) begin errs++; $display("FAIL reload2_run got cpu_en=%b done=%b exp 1 1", cpu_en, done); end
    checks++; if (wa.size() !== 2) begin errs++; $display("FAIL reload_writes got %0d exp 2", wa.size()); end
    else begin
      checks++; if (wa[0] !== 11'd7 || wd[0] !== 32'hCAFE_0007 || wa[1] !== 11'd9 || wd[1] !== 32'hCAFE_0009) begin errs++; $display("FAIL reload_content got %0d:%h %0d:%h exp 7:cafe0007 9:cafe0009", wa[0], wd[0], wa[1], wd[1]); end
    end
  endtask

  task automatic test_reset_mid;
    do_start(11'd0, 12'd5, 1'b0);
    send(32'h1); send(32'h2);
    resetn = 0;
    #1;
    checks++; if ({s_ready, w_enable, cpu_en, busy, done, err} !== 6'b0 || word_cnt !== 12'd0 || w_adrs !== 11'd0 || w_instruction !== 32'd0) begin errs++; $display("FAIL reset_mid got flags=%b cnt=%0d adrs=%0d exp all 0", {s_ready, w_enable, cpu_en, busy, done, err}, word_cnt, w_adrs); end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    wa.delete(); wd.delete();
    do_start(11'd10, 12'd2, 1'b0);
    send(32'hAA); send(32'hBB);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1) begin errs++; $display("FAIL post_reset_run got cpu_en=%b exp 1", cpu_en); end
    checks++; if (wa.size() !== 2) begin errs++; $display("FAIL post_reset_writes got %0d exp 2", wa.size()); end
    else begin
      checks++; if (wa[0] !== 11'd10 || wa[1] !== 11'd11 || wd[0] !== 32'hAA || wd[1] !== 32'hBB) begin errs++; $display("FAIL post_reset_content got %0d:%h %0d:%h exp 10:aa 11:bb", wa[0], wd[0], wa[1], wd[1]); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    wa.delete(); wd.delete();
    do_start(11'd0, 12'd2, 1'b0);
    send(32'h0000_000F); send(32'hF000_0000);
    checks++; if (s_ready !== 1'b1) begin errs++; $display("FAIL ck_trailer_ready got %b exp 1", s_ready); end
    send(32'hF000_000F);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || err !== 1'b0 || wa.size() !== 2) begin errs++; $display("FAIL ck_match got cpu_en=%b err=%b writes=%0d exp 1 0 2", cpu_en, err, wa.size()); end
    wa.delete(); wd.delete();
    do_start(11'd0, 12'd2, 1'b0);
    send(32'h0000_000F); send(32'hF000_0000); send(32'hF000_0010);
    @(negedge clk);
    checks++; if (cpu_en !== 1'b0 || err !== 1'b1 || wa.size() !== 2) begin errs++; $display("FAIL ck_mismatch got cpu_en=%b err=%b writes=%0d exp 0 1 2", cpu_en, err, wa.size()); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`else
    test_basic;
    test_backpressure;
    test_wrap_zero;
    test_err_reload;
    test_reset_mid;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
